// File: rtl/peripheral_bfm_slave_ahb3.sv
// Responder-side BFM terminating AXI3-style AW/W/B/AR/R channels onto an internal 32-bit word memory.
// Write and read paths are independent FSMs with one transaction in flight each; all outputs are registered.
module peripheral_bfm_slave_ahb3 #(
  parameter int MEM_DEPTH = 1024,
  parameter int ID_WIDTH  = 4
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awadr,
  input  logic [3:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_WIDTH-1:0] wid,
  input  logic [31:0]         wrdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [3:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, WRAP = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [31:0] mem [MEM_DEPTH];

  // Error codes are ordered by severity, so the numerically larger one wins.
  function automatic logic [1:0] sev_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] beat_err(input logic [31:0] a, input logic [3:0] len,
                                          input logic [1:0] burst, input logic [2:0] size);
    logic [1:0] e;
    e = OKAY;
    if (size != 3'b010 || burst == 2'b11) e = SLVERR;
    if (burst == WRAP && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) e = SLVERR;
    if ((a >> (AW + 2)) != 32'd0) e = DECERR;
    return e;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [1:0] burst);
    logic [31:0] mask;
    mask = ((32'(len) + 32'd1) << 2) - 32'd1;
    case (burst)
      FIXED:   return a;
      WRAP:    return (a & ~mask) | ((a + 32'd4) & mask);
      default: return a + 32'd4;
    endcase
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  wstate_t             w_state, w_state_n;
  logic [31:0]         w_addr, w_addr_n;
  logic [3:0]          w_len, w_len_n, w_cnt, w_cnt_n;
  logic [1:0]          w_burst, w_burst_n, w_err, w_err_n;
  logic [2:0]          w_size, w_size_n;
  logic                awready_n, wready_n, bvalid_n;
  logic [1:0]          bresp_n;
  logic [ID_WIDTH-1:0] bid_n;
  logic [1:0]          w_beat_err;
  logic                mem_we;

  rstate_t             r_state, r_state_n;
  logic [31:0]         r_addr, r_addr_n;
  logic [3:0]          r_len, r_len_n, r_cnt, r_cnt_n;
  logic [1:0]          r_burst, r_burst_n;
  logic [2:0]          r_size, r_size_n;
  logic                arready_n, rvalid_n, rlast_n;
  logic [1:0]          rresp_n;
  logic [31:0]         rdata_n;
  logic [ID_WIDTH-1:0] rid_n;

  logic [31:0]         ld_addr, ld_data;
  logic [3:0]          ld_len;
  logic [1:0]          ld_burst, ld_err;
  logic [2:0]          ld_size;

  logic unused_wid;
  assign unused_wid = ^wid;

  // A wlast that disagrees with the awlen-derived position flags the beat as SLVERR.
  assign w_beat_err = sev_max(beat_err(w_addr, w_len, w_burst, w_size),
                              (wlast != (w_cnt == w_len)) ? SLVERR : OKAY);
  assign mem_we     = wvalid & wready & (w_beat_err == OKAY) & ~areset;

  always_comb begin
    w_state_n = w_state;
    w_addr_n  = w_addr;
    w_len_n   = w_len;
    w_cnt_n   = w_cnt;
    w_burst_n = w_burst;
    w_size_n  = w_size;
    w_err_n   = w_err;
    awready_n = awready;
    wready_n  = wready;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    bid_n     = bid;
    case (w_state)
      W_IDLE: begin
        awready_n = 1'b1;
        if (awvalid && awready) begin
          w_addr_n  = awadr;
          w_len_n   = awlen;
          w_burst_n = awburst;
          w_size_n  = awsize;
          w_cnt_n   = 4'd0;
          w_err_n   = OKAY;
          bid_n     = awid;
          awready_n = 1'b0;
          wready_n  = 1'b1;
          w_state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready) begin
          w_err_n  = sev_max(w_err, w_beat_err);
          w_addr_n = next_addr(w_addr, w_len, w_burst);
          w_cnt_n  = w_cnt + 4'd1;
          if (w_cnt == w_len) begin
            wready_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = w_err_n;
            w_state_n = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid && bready) begin
          bvalid_n  = 1'b0;
          bresp_n   = OKAY;
          awready_n = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  // The beat being loaded onto R comes from AR in idle, otherwise from the advanced burst address.
  assign ld_addr  = (r_state == R_IDLE) ? araddr  : next_addr(r_addr, r_len, r_burst);
  assign ld_len   = (r_state == R_IDLE) ? arlen   : r_len;
  assign ld_burst = (r_state == R_IDLE) ? arburst : r_burst;
  assign ld_size  = (r_state == R_IDLE) ? arsize  : r_size;
  assign ld_err   = beat_err(ld_addr, ld_len, ld_burst, ld_size);
  assign ld_data  = (ld_err == OKAY) ? mem[widx(ld_addr)] : 32'd0;

  always_comb begin
    r_state_n = r_state;
    r_addr_n  = r_addr;
    r_len_n   = r_len;
    r_cnt_n   = r_cnt;
    r_burst_n = r_burst;
    r_size_n  = r_size;
    arready_n = arready;
    rvalid_n  = rvalid;
    rlast_n   = rlast;
    rresp_n   = rresp;
    rdata_n   = rdata;
    rid_n     = rid;
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (arvalid && arready) begin
          r_addr_n  = araddr;
          r_len_n   = arlen;
          r_burst_n = arburst;
          r_size_n  = arsize;
          r_cnt_n   = 4'd0;
          rid_n     = arid;
          arready_n = 1'b0;
          rvalid_n  = 1'b1;
          rdata_n   = ld_data;
          rresp_n   = ld_err;
          rlast_n   = (arlen == 4'd0);
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid && rready) begin
          if (r_cnt == r_len) begin
            rvalid_n  = 1'b0;
            rlast_n   = 1'b0;
            rresp_n   = OKAY;
            rdata_n   = 32'd0;
            arready_n = 1'b1;
            r_state_n = R_IDLE;
          end else begin
            r_addr_n = ld_addr;
            r_cnt_n  = r_cnt + 4'd1;
            rdata_n  = ld_data;
            rresp_n  = ld_err;
            rlast_n  = ((r_cnt + 4'd1) == r_len);
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_size  <= '0;
      w_err   <= OKAY;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      bid     <= '0;
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_size  <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= OKAY;
      rdata   <= '0;
      rid     <= '0;
    end else begin
      w_state <= w_state_n;
      w_addr  <= w_addr_n;
      w_len   <= w_len_n;
      w_cnt   <= w_cnt_n;
      w_burst <= w_burst_n;
      w_size  <= w_size_n;
      w_err   <= w_err_n;
      awready <= awready_n;
      wready  <= wready_n;
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
      bid     <= bid_n;
      r_state <= r_state_n;
      r_addr  <= r_addr_n;
      r_len   <= r_len_n;
      r_cnt   <= r_cnt_n;
      r_burst <= r_burst_n;
      r_size  <= r_size_n;
      arready <= arready_n;
      rvalid  <= rvalid_n;
      rlast   <= rlast_n;
      rresp   <= rresp_n;
      rdata   <= rdata_n;
      rid     <= rid_n;
    end
  end

  // Memory is never cleared by reset; a same-edge read above sees the pre-write word.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[widx(w_addr)][8*i +: 8] <= wrdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_peripheral_bfm_slave_ahb3.sv
// Self-checking bench for peripheral_bfm_slave_ahb3: directed scenarios plus randomized bursts
// checked against a word-array memory model with per-beat address/error arithmetic.
module tb_peripheral_bfm_slave_ahb3;
  localparam int DEPTH = 1024;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid, wid, bid, arid, rid;
  logic [31:0] awadr, wrdata, araddr, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  peripheral_bfm_slave_ahb3 #(.MEM_DEPTH(DEPTH), .ID_WIDTH(4)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wdata_q [16];
  logic [3:0]  wstrb_q [16];
  logic        wlast_q [16];
  int n_cmp = 0;
  int n_err = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat address from the burst rules: plain offset arithmetic, wrap by modulo inside the aligned block.
  function automatic logic [31:0] beatAddr(input logic [31:0] start, input int len,
                                           input logic [1:0] burst, input int k);
    logic [31:0] blk, base;
    blk  = 32'((len + 1) * 4);
    base = start - (start % blk);
    case (burst)
      2'b00:   return start;
      2'b10:   return base + ((start - base + 32'(4 * k)) % blk);
      default: return start + 32'(4 * k);
    endcase
  endfunction

  function automatic logic [1:0] beatErr(input logic [31:0] a, input int len,
                                         input logic [2:0] size, input logic [1:0] burst);
    if (a >= 32'(4 * DEPTH)) return 2'b11;
    if (size != 3'd2 || burst == 2'b11) return 2'b10;
    if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic setBeats(input int len, input logic [31:0] d, input bit rnd);
    for (int k = 0; k < 16; k++) begin
      wdata_q[k] = rnd ? $urandom : d + 32'(k);
      wstrb_q[k] = 4'hF;
      wlast_q[k] = (k == len);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_awready"}, awready, 0);
    checkOutput({tag, "_wready"},  wready,  0);
    checkOutput({tag, "_bvalid"},  bvalid,  0);
    checkOutput({tag, "_bid"},     bid,     0);
    checkOutput({tag, "_bresp"},   bresp,   0);
    checkOutput({tag, "_arready"}, arready, 0);
    checkOutput({tag, "_rvalid"},  rvalid,  0);
    checkOutput({tag, "_rid"},     rid,     0);
    checkOutput({tag, "_rdata"},   rdata,   0);
    checkOutput({tag, "_rresp"},   rresp,   0);
    checkOutput({tag, "_rlast"},   rlast,   0);
  endtask

  task automatic applyReset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkAllZero("reset");
    areset = 1'b0;
    @(posedge aclk); #1;
    checkOutput("reset_awready_up", awready, 1);
    checkOutput("reset_arready_up", arready, 1);
  endtask

  task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int gap, input int bstall);
    logic [1:0]  e, exp_resp;
    logic [31:0] a;
    int t;
    awid = id; awadr = addr; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (awready !== 1'b1 && t < 8) begin @(posedge aclk); #1; t++; end
    checkOutput("awready", awready, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    exp_resp = 2'b00;
    for (int k = 0; k <= len; k++) begin
      if (gap > 0 && k > 0) begin
        wvalid = 1'b0;
        repeat (gap) begin @(posedge aclk); #1; end
      end
      a = beatAddr(addr, len, burst, k);
      e = beatErr(a, len, size, burst);
      if (wlast_q[k] != (k == len) && e < 2'b10) e = 2'b10;
      wid = id; wrdata = wdata_q[k]; wstrb = wstrb_q[k]; wlast = wlast_q[k]; wvalid = 1'b1;
      checkOutput("wready", wready, 1);
      @(posedge aclk); #1;
      if (e == 2'b00)
        for (int b = 0; b < 4; b++)
          if (wstrb_q[k][b]) model_mem[int'(a >> 2)][8*b +: 8] = wdata_q[k][8*b +: 8];
      if (e > exp_resp) exp_resp = e;
    end
    wvalid = 1'b0; wlast = 1'b0;
    checkOutput("bvalid", bvalid, 1);
    checkOutput("bid", bid, id);
    checkOutput("bresp", bresp, exp_resp);
    repeat (bstall) begin
      @(posedge aclk); #1;
      checkOutput("bvalid_hold", bvalid, 1);
      checkOutput("bresp_hold", bresp, exp_resp);
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    checkOutput("bvalid_clear", bvalid, 0);
    checkOutput("awready_back", awready, 1);
  endtask

  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_k, input int stall_n);
    logic [1:0]  e;
    logic [31:0] a, expd;
    int t;
    arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (arready !== 1'b1 && t < 8) begin @(posedge aclk); #1; t++; end
    checkOutput("arready", arready, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      a    = beatAddr(addr, len, burst, k);
      e    = beatErr(a, len, size, burst);
      expd = (e == 2'b00) ? model_mem[int'(a >> 2)] : 32'd0;
      checkOutput("rvalid", rvalid, 1);
      checkOutput("rdata", rdata, expd);
      checkOutput("rresp", rresp, e);
      checkOutput("rid", rid, id);
      checkOutput("rlast", rlast, (k == len));
      if (k == stall_k) begin
        rready = 1'b0;
        repeat (stall_n) begin
          @(posedge aclk); #1;
          checkOutput("rvalid_hold", rvalid, 1);
          checkOutput("rdata_hold", rdata, expd);
          checkOutput("rresp_hold", rresp, e);
          checkOutput("rlast_hold", rlast, (k == len));
        end
      end
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
    end
    checkOutput("rvalid_clear", rvalid, 0);
    checkOutput("arready_back", arready, 1);
  endtask

  // Randomized mixed traffic, including out-of-range addresses and occasional bad sizes.
  task automatic applyStimulus(input int n);
    int lens [4] = '{1, 3, 7, 15};
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [31:0] addr;
    int len;
    for (int i = 0; i < n; i++) begin
      burst = 2'($urandom_range(0, 2));
      len   = (burst == 2'b10) ? lens[$urandom_range(0, 3)] : int'($urandom_range(0, 15));
      size  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      addr  = 32'($urandom_range(0, 4 * DEPTH + 64));
      if ($urandom_range(0, 1) == 1) begin
        setBeats(len, 0, 1);
        for (int k = 0; k < 16; k++) wstrb_q[k] = 4'($urandom);
        writeBurst(4'($urandom), addr, len, size, burst, int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
      end else begin
        readBurst(4'($urandom), addr, len, size, burst, int'($urandom_range(0, len)),
                  int'($urandom_range(0, 3)));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] old_word;
    areset = 1'b1;
    awid = '0; awadr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wrdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    applyReset();

    // Give every word a known random value so the model can predict any read.
    for (int base = 0; base < 4 * DEPTH; base += 64) begin
      setBeats(15, 0, 1);
      writeBurst(4'h1, 32'(base), 15, 3'd2, 2'b01, 0, 0);
    end

    // Single write/read round trip.
    setBeats(0, 32'hDEADBEEF, 0);
    writeBurst(4'h3, 32'h10, 0, 3'd2, 2'b01, 0, 0);
    readBurst(4'h5, 32'h10, 0, 3'd2, 2'b01, 0, 0);

    // INCR burst with a partial strobe over an all-ones fill.
    setBeats(3, 32'hFFFFFFFF, 0);
    for (int k = 0; k < 4; k++) wdata_q[k] = 32'hFFFFFFFF;
    writeBurst(4'h2, 32'h40, 3, 3'd2, 2'b01, 0, 0);
    setBeats(3, 32'd1, 0);
    wstrb_q[2] = 4'b0011;
    writeBurst(4'h2, 32'h40, 3, 3'd2, 2'b01, 1, 2);
    readBurst(4'h6, 32'h40, 3, 3'd2, 2'b01, 4, 0);
    checkOutput("t2_model_beat3", model_mem[32'h48 >> 2], 32'hFFFF0003);

    // WRAP read with a stall on the second beat.
    readBurst(4'h7, 32'h38, 3, 3'd2, 2'b10, 1, 3);

    // Error responses.
    setBeats(0, 32'hCAFEF00D, 0);
    writeBurst(4'h4, 32'(4 * DEPTH), 0, 3'd2, 2'b01, 0, 0);
    readBurst(4'h4, 32'(4 * DEPTH), 0, 3'd2, 2'b01, 0, 0);
    writeBurst(4'h8, 32'h20, 0, 3'd1, 2'b01, 0, 0);
    readBurst(4'h8, 32'h20, 0, 3'd2, 2'b01, 0, 0);
    setBeats(1, 32'h11110000, 0);
    writeBurst(4'h9, 32'h24, 1, 3'd2, 2'b11, 0, 0);
    readBurst(4'h9, 32'h30, 2, 3'd2, 2'b10, 0, 0);
    readBurst(4'h9, 32'hFF8, 3, 3'd2, 2'b01, 0, 0);

    // FIXED burst: every beat lands on the same word.
    setBeats(3, 32'h5000, 0);
    writeBurst(4'hA, 32'h50, 3, 3'd2, 2'b00, 0, 0);
    readBurst(4'hA, 32'h50, 1, 3'd2, 2'b00, 0, 0);

    // Early wlast: length still follows awlen.
    setBeats(2, 32'h7700, 0);
    wlast_q[1] = 1'b1; wlast_q[2] = 1'b0;
    writeBurst(4'hB, 32'h300, 2, 3'd2, 2'b01, 0, 0);

    // Same-edge write and read of one word: read sees the old data.
    old_word = model_mem[32'h80 >> 2];
    awid = 4'hC; awadr = 32'h80; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wrdata = 32'h12345678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 4'hD; araddr = 32'h80; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    checkOutput("rw_wready", wready, 1);
    checkOutput("rw_arready", arready, 1);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    model_mem[32'h80 >> 2] = 32'h12345678;
    checkOutput("rw_rdata_old", rdata, old_word);
    checkOutput("rw_bvalid", bvalid, 1);
    rready = 1'b1; bready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0; bready = 1'b0;
    checkOutput("rw_rvalid_clear", rvalid, 0);
    checkOutput("rw_bvalid_clear", bvalid, 0);
    readBurst(4'hD, 32'h80, 0, 3'd2, 2'b01, 0, 0);

    // Reset mid-burst on both channels.
    awid = 4'hE; awadr = 32'h200; awlen = 4'd1; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'hF; araddr = 32'h100; arlen = 4'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    checkOutput("t6_awready", awready, 1);
    checkOutput("t6_arready", arready, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    wrdata = 32'hA5A55A5A; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1; rready = 1'b1;
    checkOutput("t6_rdata_beat1", rdata, model_mem[32'h100 >> 2]);
    @(posedge aclk); #1;
    wvalid = 1'b0; rready = 1'b0;
    model_mem[32'h200 >> 2] = 32'hA5A55A5A;
    checkOutput("t6_rdata_beat2", rdata, model_mem[32'h104 >> 2]);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    checkAllZero("t6");
    @(posedge aclk); #1;
    checkOutput("t6_no_bvalid", bvalid, 0);
    setBeats(1, 32'h6600, 0);
    writeBurst(4'h1, 32'h208, 1, 3'd2, 2'b01, 0, 0);
    readBurst(4'h2, 32'h200, 3, 3'd2, 2'b01, 0, 0);

    applyStimulus(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/peripheral_bfm_slave_ahb3.md
Name: peripheral_bfm_slave_ahb3

Overview:
Responder-side bus functional model that terminates the master BFM's AXI3-style channels (AW/W/B/AR/R) in verification benches.
- Backed by an internal 32-bit word memory.
- Accepts single and burst writes/reads, applies byte strobes, and returns OKAY/SLVERR/DECERR responses.
- Write and read paths are independent state machines, each with one transaction outstanding.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words in memory (power of two); valid byte addresses 0 .. 4*MEM_DEPTH-1
ID_WIDTH, 4, width of awid/wid/bid/arid/rid

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous active-high reset
awid  in  ID_WIDTH  write address ID
awadr  in  32  write start byte address
awlen  in  4  write burst length minus 1
awsize  in  3  write beat size
awburst  in  2  write burst type
awvalid  in  1  write address valid
awready  out  1  write address ready
wid  in  ID_WIDTH  write data ID (not checked)
wrdata  in  32  write data
wstrb  in  4  byte strobes
wlast  in  1  last write beat
wvalid  in  1  write data valid
wready  out  1  write data ready
bid  out  ID_WIDTH  response ID (=latched awid)
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  response ready
arid  in  ID_WIDTH  read address ID
araddr  in  32  read start byte address
arlen  in  4  read burst length minus 1
arsize  in  3  read beat size
arburst  in  2  read burst type
arvalid  in  1  read address valid
arready  out  1  read address ready
rid  out  ID_WIDTH  read ID (=latched arid)
rdata  out  32  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Reset (areset=1 at a clock edge): all outputs 0, both FSMs return to IDLE from any state. In-flight bursts are abandoned; no response is issued. Memory contents are not cleared.
- Handshake: a transfer occurs on a rising edge with valid&ready both 1. Once bvalid/rvalid is asserted, it and its payload stay stable until the handshake.
- Word index = addr[log2(MEM_DEPTH)+1:2]. Addresses are byte addresses; addr[1:0] is ignored.
- Address advance per beat:
  - FIXED (00): unchanged.
  - INCR (01): +4.
  - WRAP (10): +4, wrapping inside an aligned block of (len+1)*4 bytes; len must be 1, 3, 7 or 15, otherwise SLVERR.
  - 11: SLVERR.
- awsize/arsize != 3'b010 -> SLVERR for the whole burst.
- Beat address >= 4*MEM_DEPTH -> DECERR for that beat.
- On any error beat: write suppressed; read returns rdata=0.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/burst/size, clear beat count and error, go to W_DATA (awready=0, wready=1 next cycle).
  - W_DATA: on each W handshake, write the bytes enabled by wstrb if the beat is error-free, then advance address and count.
    - On beat count==awlen: go to W_RESP.
    - If wlast != (count==awlen) on any beat: SLVERR. The burst length is set by awlen, not by wlast.
  - W_RESP: bvalid=1, bid=latched id. bresp = most severe error seen (DECERR > SLVERR > OKAY). On B handshake, go to W_IDLE; awready=1 the following cycle.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch fields, go to R_DATA.
  - R_DATA: rvalid=1 from the cycle after the AR handshake. rdata is the memory word at the current beat address; rresp is per beat; rlast=(count==arlen).
    - On R handshake, advance to the next beat with no bubble.
    - After the last beat, go to R_IDLE.
- Minimum latencies: AR handshake to first rvalid = 1 cycle. Last W beat to bvalid = 1 cycle.
- Simultaneous write and read to the same word in one cycle: the read returns the pre-write data.
- Back-to-back transactions: one idle cycle in IDLE (ready=1) between transactions on each channel.

Test Plan:
1. Reset, then AW addr=0x10 len=0 INCR size=2 id=3; W 0xDEADBEEF strb=F wlast=1 -> bvalid next cycle, bid=3, bresp=00. AR same addr id=5 -> rdata=0xDEADBEEF, rid=5, rlast=1, rresp=00.
2. INCR write len=3 at 0x40 with data 1,2,3,4, wstrb=4'b0011 on beat 2 over prior 0xFFFFFFFF fill -> read-back 1, 2, 0xFFFF0003, 4; rlast only on beat 4.
3. WRAP read len=3 at 0x38 -> beat addresses 0x38, 0x3C, 0x30, 0x34. Hold rready=0 for 3 cycles on beat 2 -> rdata/rresp/rlast stable throughout.
4. Write at 4*MEM_DEPTH -> bresp=11, memory unchanged. Read there -> rresp=11, rdata=0. Write with awsize=1 -> bresp=10.
5. Write len=2 with wlast asserted on beat 2 -> three beats accepted, bresp=10.
6. Assert areset mid-burst (read beat 2 of 4, write beat 1 of 2) -> all outputs 0 next cycle, no bvalid. Next transaction completes normally.
